display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 90 +++++++++
 tb/tb_display_scan_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed hex display scanner with a one-entry pending buffer that is
// swapped into the display register only at frame boundaries. Optional macro: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [4*NUM_DIGITS-1:0] i_data_in,
  input  logic                    i_data_valid,
  output logic                    o_data_ready,
  output logic [3:0]              o_seg_val,
  output logic [NUM_DIGITS-1:0]   o_digit_sel,
  output logic                    o_frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] LAST_PRE = PW'(SCAN_DIV - 1);

  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_disp;
  logic [4*NUM_DIGITS-1:0] r_pend;
  logic                    r_ready;

  logic                    w_tick;
  logic                    w_boundary;
  logic [3:0]              w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;

  assign w_tick     = (r_pre == LAST_PRE);
  assign w_boundary = w_tick && (r_idx == LAST_IDX);

  // r_ready doubles as the "pending buffer empty" flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_disp  <= '0;
      r_pend  <= '0;
      r_ready <= 1'b1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PW'(1);
      if (w_tick)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
      if (w_boundary && !r_ready) begin
        r_disp  <= r_pend;
        r_ready <= 1'b1;
      end else if (r_ready && i_data_valid) begin
        r_pend  <= i_data_in;
        r_ready <= 1'b0;
      end
    end
  end

  always_comb begin
    w_seg = '0;
    w_sel = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_seg    = r_disp[4*k +: 4];
        w_sel[k] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;

  // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 is always lit
  always_comb begin
    w_msd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_disp[4*k +: 4] != 4'h0)
        w_msd = IW'(k);
    end
  end

  assign o_digit_sel = (r_idx <= w_msd) ? w_sel : '0;
`else
  assign o_digit_sel = w_sel;
`endif

  assign o_seg_val    = w_seg;
  assign o_data_ready = r_ready;
  assign o_frame_done = w_boundary;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (NUM_DIGITS=8, SCAN_DIV=4): cycle-count based model
// checked every cycle, plus directed literal expectations per scenario.
module tb_display_scan_ctrl;

  localparam int ND = 8;
  localparam int SD = 4;
  localparam int FR = ND * SD;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din   = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [3:0]  seg;
  logic [7:0]  sel;
  logic        fd;

  always #5 clk = ~clk;

  display_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_data_in    (din),
    .i_data_valid (valid),
    .o_data_ready (ready),
    .o_seg_val    (seg),
    .o_digit_sel  (sel),
    .o_frame_done (fd)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: t = clock edges since reset release; slot and frame derive from t alone
  int          t;
  logic [31:0] m_disp;
  logic [31:0] m_pend;
  bit          m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t      <= 0;
      m_disp <= '0;
      m_pend <= '0;
      m_full <= 1'b0;
    end else begin
      if ((t % FR == FR - 1) && m_full) begin
        m_disp <= m_pend;
        m_full <= 1'b0;
      end else if (!m_full && valid) begin
        m_pend <= din;
        m_full <= 1'b1;
      end
      t <= t + 1;
    end
  end

  function automatic logic [3:0] exp_seg();
    int i = (t / SD) % ND;
    return 4'((m_disp >> (4 * i)) & 32'hF);
  endfunction

  function automatic logic [7:0] exp_sel();
    int i = (t / SD) % ND;
    int msd = 0;
    logic [7:0] s = 8'(1 << i);
    for (int k = 0; k < ND; k++)
      if (((m_disp >> (4 * k)) & 32'hF) != 0) msd = k;
    if (BLANK && i > msd) s = '0;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_seg",   32'(seg),   32'(exp_seg()));
      chk("model_sel",   32'(sel),   32'(exp_sel()));
      chk("model_ready", 32'(ready), 32'(!m_full));
      chk("model_fd",    32'(fd),    32'(t % FR == FR - 1));
    end
  end

  task automatic at_t(input int target);
    int n = 0;
    while (t != target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (t != target) begin
      checks++;
      errors++;
      $display("FAIL timeout waiting t=%0d got t=%0d", target, t);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    valid = 1'b0;
    #1;
    chk("rst_seg",   32'(seg),   32'h0);
    chk("rst_sel",   32'(sel),   32'h01);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_fd",    32'(fd),    32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    // Reset release and scan order
    do_reset();
    cmp_en = 1'b1;
    at_t(0);  chk("rel_sel", 32'(sel), 32'h01); chk("rel_ready", 32'(ready), 32'h1);
    at_t(3);  chk("scan_sel3", 32'(sel), 32'h01);
    at_t(4);  chk("scan_sel4", 32'(sel), BLANK ? 32'h00 : 32'h02);
    at_t(28); chk("scan_sel28", 32'(sel), BLANK ? 32'h00 : 32'h80);
    at_t(30); chk("scan_fd30", 32'(fd), 32'h0);
    at_t(31); chk("scan_fd31", 32'(fd), 32'h1);
    at_t(32); chk("scan_sel32", 32'(sel), 32'h01); chk("scan_fd32", 32'(fd), 32'h0);
    at_t(63); chk("scan_fd63", 32'(fd), 32'h1);

    // Load 1234ABCD one cycle after reset
    do_reset();
    at_t(1);  din = 32'h1234ABCD; valid = 1'b1;
    at_t(2);  valid = 1'b0; chk("load_ready2", 32'(ready), 32'h0);
    at_t(31); chk("load_seg31", 32'(seg), 32'h0); chk("load_ready31", 32'(ready), 32'h0);
    at_t(32); chk("load_seg32", 32'(seg), 32'hD); chk("load_ready32", 32'(ready), 32'h1);
              chk("load_sel32", 32'(sel), 32'h01);
    at_t(36); chk("load_seg36", 32'(seg), 32'hC);
    at_t(48); chk("load_seg48", 32'(seg), 32'h4);
    at_t(60); chk("load_seg60", 32'(seg), 32'h1); chk("load_sel60", 32'(sel), 32'h80);

    // Back-pressure: 22222222 held while 11111111 is pending
    do_reset();
    at_t(1);  din = 32'h11111111; valid = 1'b1;
    at_t(2);  din = 32'h22222222; chk("bp_ready2", 32'(ready), 32'h0);
    at_t(31); chk("bp_seg31", 32'(seg), 32'h0);
    at_t(32); chk("bp_seg32", 32'(seg), 32'h1); chk("bp_ready32", 32'(ready), 32'h1);
    at_t(33); chk("bp_ready33", 32'(ready), 32'h0); valid = 1'b0;
    at_t(63); chk("bp_seg63", 32'(seg), 32'h1);
    at_t(64); chk("bp_seg64", 32'(seg), 32'h2); chk("bp_ready64", 32'(ready), 32'h1);

    // Reset mid-frame at index 5 with 99999999 pending
    do_reset();
    at_t(1);  din = 32'h55555555; valid = 1'b1;
    at_t(2);  valid = 1'b0;
    at_t(33); din = 32'h99999999; valid = 1'b1;
    at_t(34); valid = 1'b0; chk("mr_ready34", 32'(ready), 32'h0);
    at_t(52); chk("mr_seg52", 32'(seg), 32'h5); chk("mr_sel52", 32'(sel), 32'h20);
    do_reset();
    at_t(3);  chk("mr_sel3", 32'(sel), 32'h01); chk("mr_seg3", 32'(seg), 32'h0);
    at_t(4);  chk("mr_sel4", 32'(sel), BLANK ? 32'h00 : 32'h02);
    at_t(32); chk("mr_seg32", 32'(seg), 32'h0); chk("mr_ready32", 32'(ready), 32'h1);
    at_t(52); chk("mr_seg52b", 32'(seg), 32'h0);

    // Value 00000050: blanking above digit 1 when enabled
    do_reset();
    at_t(1);  din = 32'h00000050; valid = 1'b1;
    at_t(2);  valid = 1'b0;
    at_t(32); chk("lz_seg32", 32'(seg), 32'h0); chk("lz_sel32", 32'(sel), 32'h01);
    at_t(36); chk("lz_seg36", 32'(seg), 32'h5); chk("lz_sel36", 32'(sel), 32'h02);
    at_t(40); chk("lz_seg40", 32'(seg), 32'h0); chk("lz_sel40", 32'(sel), BLANK ? 32'h00 : 32'h04);
    at_t(60); chk("lz_sel60", 32'(sel), BLANK ? 32'h00 : 32'h80);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
